// File: rtl/io_switch_egress_buffer.sv
// io_switch_egress_buffer
//   Elastic first-word-fall-through buffer for one output port of the 4x4
//   streaming I/O switch. It absorbs consumer backpressure and exposes
//   occupancy, a high-water mark and a saturating delivered-beat counter.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_valid  : beat from the switch output port
//   in_ready          : buffer can accept a beat (registered state only)
//   out_data/out_valid: head-of-queue beat to the consumer (FWFT)
//   out_ready         : consumer accepts the beat
//   level/full/empty  : current occupancy and its flags
//   high_water        : maximum level since reset or the last clr_stats
//   beat_count        : saturating count of delivered beats
//   clr_stats         : clears high_water (to next level) and beat_count
module io_switch_egress_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   high_water,
  output logic [CNT_WIDTH-1:0]     beat_count,
  input  logic                     clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [LW-1:0]         r_high_water;
  logic [CNT_WIDTH-1:0]  r_beat_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [LW-1:0]         w_level_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [LW-1:0] max_level(input logic [LW-1:0] a,
                                              input logic [LW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Flags come only from the registered level, so in_ready has no path
  // from out_ready: a slot freed by a pop becomes usable one cycle later.
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (w_pop && !w_push) w_level_nxt = r_level - LW'(1);
  end

  // Storage is deliberately left unreset; only pointers and counters are.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_high_water <= '0;
      r_beat_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      // Clearing reloads the mark with the current occupancy, not zero.
      if (clr_stats) r_high_water <= w_level_nxt;
      else           r_high_water <= max_level(r_high_water, w_level_nxt);
      // Clear takes priority over a coincident pop.
      if (clr_stats)  r_beat_count <= '0;
      else if (w_pop) r_beat_count <= sat_inc(r_beat_count);
    end
  end

  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign out_data   = r_mem[r_rd_ptr];
  assign level      = r_level;
  assign full       = w_full;
  assign empty      = w_empty;
  assign high_water = r_high_water;
  assign beat_count = r_beat_count;

endmodule
